// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types for the cpu control sequencer: sequencer state
//               encoding and the decoded instruction op class seen on the
//               op_class input.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

  localparam int OP_CLASS_W = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  // Codes 6 and 7 are reserved and treated as illegal instructions.
  typedef enum logic [OP_CLASS_W-1:0] {
    OP_NOP  = 3'd0,
    OP_ALU  = 3'd1,
    OP_ALUI = 3'd2,
    OP_BRZ  = 3'd3,
    OP_JMP  = 3'd4,
    OP_HALT = 3'd5
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Registered rising-edge detector. The delayed copy of sig is
//               updated every cycle, so a level held high yields one pulse.
// Ports       : clk, n_reset (async active-low)
//               sig  - synchronised input level
//               rise - high while sig=1 and the previous sampled value was 0
// Revision    : 1.0  initial release
// ============================================================================
module edge_detect (
  input  logic clk,
  input  logic n_reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle control sequencer for the cpu datapath. Steps each
//               instruction through FETCH / DECODE / EXECUTE with a req/ack
//               handshake to program memory, in free-run or single-step mode.
// Ports       : clk, n_reset (async active-low)
//               imem_ack, op_class, z_flag, step_mode, step  - control inputs
//               imem_req, ir_load, pc_incr, pc_load, rf_we   - datapath enables
//               halted, fault                                - terminal states
//               instr_count                                  - retired count
// Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  imem_ack,
  input  logic [OP_CLASS_W-1:0] op_class,
  input  logic                  z_flag,
  input  logic                  step_mode,
  input  logic                  step,
  output logic                  imem_req,
  output logic                  ir_load,
  output logic                  pc_incr,
  output logic                  pc_load,
  output logic                  rf_we,
  output logic                  halted,
  output logic                  fault,
  output logic [CW-1:0]         instr_count
);

  // Wait counter value on the last permitted FETCH cycle without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t    state;
  logic [7:0] wait_cnt;
  logic      step_rise;
  op_class_t op;

  assign op = op_class_t'(op_class);

  edge_detect u_step_edge (
    .clk     (clk),
    .n_reset (n_reset),
    .sig     (step),
    .rise    (step_rise)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!step_mode || step_rise) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state    <= S_DECODE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_FAULT;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          case (op)
            OP_NOP, OP_ALU, OP_ALUI, OP_BRZ, OP_JMP: begin
              // Retire; step_mode is only sampled here and in IDLE.
              if (instr_count != COUNT_MAX) begin
                instr_count <= instr_count + COUNT_ONE;
              end
              state <= step_mode ? S_IDLE : S_FETCH;
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_FAULT;
          endcase
        end
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  // Enables decode from state (and same-cycle inputs); reset forces IDLE,
  // so every enable drops as soon as n_reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_incr  = 1'b0;
    pc_load  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_EXECUTE: begin
        case (op)
          OP_NOP:         pc_incr = 1'b1;
          OP_ALU, OP_ALUI: begin
            rf_we   = 1'b1;
            pc_incr = 1'b1;
          end
          OP_BRZ: begin
            pc_load = z_flag;
            pc_incr = ~z_flag;
          end
          OP_JMP:         pc_load = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Directed self-checking bench for cpu_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

  // Output vector order: {imem_req, ir_load, pc_incr, pc_load, rf_we, halted, fault}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_FACK   = 7'b1100000;
  localparam logic [6:0] O_FNOACK = 7'b1000000;
  localparam logic [6:0] O_EXALU  = 7'b0010100;
  localparam logic [6:0] O_INCR   = 7'b0010000;
  localparam logic [6:0] O_LOAD   = 7'b0001000;
  localparam logic [6:0] O_HALT   = 7'b0000010;
  localparam logic [6:0] O_FAULT  = 7'b0000001;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        imem_ack = 1'b0;
  logic [2:0]  op_class = 3'd0;
  logic        z_flag = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        imem_req, ir_load, pc_incr, pc_load, rf_we, halted, fault;
  logic [15:0] instr_count;
  logic [6:0]  outs;

  int passed = 0;
  int total  = 0;

  assign outs = {imem_req, ir_load, pc_incr, pc_load, rf_we, halted, fault};

  always #5 clk = ~clk;

  cpu_sequencer #(.CW(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .imem_ack    (imem_ack),
    .op_class    (op_class),
    .z_flag      (z_flag),
    .step_mode   (step_mode),
    .step        (step),
    .imem_req    (imem_req),
    .ir_load     (ir_load),
    .pc_incr     (pc_incr),
    .pc_load     (pc_load),
    .rf_we       (rf_we),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic sm);
    n_reset   = 1'b0;
    step_mode = sm;
    step      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    imem_ack = 1'b1; op_class = 3'd1;
    n_reset = 1'b0;
    @(posedge clk); #2;
    total++;
    if (outs !== O_NONE) $display("FAIL reset_outs: got %b exp %b", outs, O_NONE); else passed++;
    total++;
    if (instr_count !== 16'd0) $display("FAIL reset_count: got %0d exp 0", instr_count); else passed++;
  endtask

  task automatic test_free_run();
    logic [6:0] exp_tab [3];
    exp_tab = '{O_FACK, O_NONE, O_EXALU};
    imem_ack = 1'b1; op_class = 3'd1; z_flag = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc();
      total++;
      if (outs !== exp_tab[i % 3])
        $display("FAIL free_run_cyc%0d: got %b exp %b", i + 1, outs, exp_tab[i % 3]);
      else passed++;
    end
    cyc();
    total++;
    if (instr_count !== 16'd3) $display("FAIL free_run_count: got %0d exp 3", instr_count); else passed++;
  endtask

  task automatic test_wait_states();
    logic [6:0] exp_tab [5];
    int loads;
    exp_tab = '{O_FNOACK, O_FNOACK, O_FACK, O_NONE, O_EXALU};
    loads = 0;
    imem_ack = 1'b0; op_class = 3'd1;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      imem_ack = (i == 2);
      #1;
      if (ir_load) loads++;
      total++;
      if (outs !== exp_tab[i])
        $display("FAIL wait_cyc%0d: got %b exp %b", i + 1, outs, exp_tab[i]);
      else passed++;
    end
    total++;
    if (loads !== 1) $display("FAIL wait_ir_load_count: got %0d exp 1", loads); else passed++;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    #1;
    total++;
    if (outs !== O_FNOACK) $display("FAIL wait_next_fetch: got %b exp %b", outs, O_FNOACK); else passed++;
    total++;
    if (instr_count !== 16'd1) $display("FAIL wait_count: got %0d exp 1", instr_count); else passed++;
  endtask

  task automatic test_timeout();
    imem_ack = 1'b1; op_class = 3'd1;
    do_reset(1'b0);
    cyc(); cyc();
    imem_ack = 1'b0;
    cyc();
    for (int i = 0; i < 15; i++) begin
      cyc();
      total++;
      if (outs !== O_FNOACK) $display("FAIL timeout_fetch%0d: got %b exp %b", i + 1, outs, O_FNOACK);
      else passed++;
    end
    cyc();
    total++;
    if (outs !== O_FAULT) $display("FAIL timeout_fault: got %b exp %b", outs, O_FAULT); else passed++;
    imem_ack = 1'b1;
    repeat (3) cyc();
    total++;
    if (outs !== O_FAULT) $display("FAIL timeout_fault_sticky: got %b exp %b", outs, O_FAULT); else passed++;
    total++;
    if (instr_count !== 16'd1) $display("FAIL timeout_count: got %0d exp 1", instr_count); else passed++;
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; op_class = 3'd3; z_flag = 1'b1;
    do_reset(1'b0);
    cyc(); cyc(); cyc();
    total++;
    if (outs !== O_LOAD) $display("FAIL brz_taken: got %b exp %b", outs, O_LOAD); else passed++;
    z_flag = 1'b0; #1;
    total++;
    if (outs !== O_INCR) $display("FAIL brz_not_taken: got %b exp %b", outs, O_INCR); else passed++;
    op_class = 3'd4; #1;
    total++;
    if (outs !== O_LOAD) $display("FAIL jmp: got %b exp %b", outs, O_LOAD); else passed++;
    op_class = 3'd0; #1;
    total++;
    if (outs !== O_INCR) $display("FAIL nop: got %b exp %b", outs, O_INCR); else passed++;
    cyc();
    total++;
    if (instr_count !== 16'd1) $display("FAIL branch_count: got %0d exp 1", instr_count); else passed++;
  endtask

  task automatic test_single_step();
    imem_ack = 1'b1; op_class = 3'd1;
    do_reset(1'b1);
    repeat (4) cyc();
    total++;
    if (outs !== O_NONE) $display("FAIL step_wait_idle: got %b exp %b", outs, O_NONE); else passed++;
    step = 1'b1;
    cyc();
    total++;
    if (outs !== O_FACK) $display("FAIL step_fetch: got %b exp %b", outs, O_FACK); else passed++;
    cyc(); cyc();
    total++;
    if (outs !== O_EXALU) $display("FAIL step_exec: got %b exp %b", outs, O_EXALU); else passed++;
    repeat (4) cyc();
    total++;
    if (outs !== O_NONE) $display("FAIL step_held_idle: got %b exp %b", outs, O_NONE); else passed++;
    total++;
    if (instr_count !== 16'd1) $display("FAIL step_held_count: got %0d exp 1", instr_count); else passed++;
    step = 1'b0;
    cyc();
    step = 1'b1;
    cyc();
    total++;
    if (outs !== O_FACK) $display("FAIL step2_fetch: got %b exp %b", outs, O_FACK); else passed++;
    step = 1'b0;
    cyc();
    step = 1'b1;   // rising edge while in DECODE
    cyc(); cyc();
    repeat (3) cyc();
    total++;
    if (outs !== O_NONE) $display("FAIL step_decode_edge_ignored: got %b exp %b", outs, O_NONE); else passed++;
    total++;
    if (instr_count !== 16'd2) $display("FAIL step2_count: got %0d exp 2", instr_count); else passed++;
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; op_class = 3'd1;
    do_reset(1'b0);
    cyc(); cyc(); cyc();
    cyc();
    op_class = 3'd5;
    cyc(); cyc();
    total++;
    if (outs !== O_NONE) $display("FAIL halt_exec: got %b exp %b", outs, O_NONE); else passed++;
    repeat (3) cyc();
    total++;
    if (outs !== O_HALT) $display("FAIL halt_state: got %b exp %b", outs, O_HALT); else passed++;
    total++;
    if (instr_count !== 16'd1) $display("FAIL halt_count: got %0d exp 1", instr_count); else passed++;
  endtask

  task automatic test_illegal();
    imem_ack = 1'b1; op_class = 3'd7;
    do_reset(1'b0);
    cyc(); cyc(); cyc();
    total++;
    if (outs !== O_NONE) $display("FAIL illegal_exec: got %b exp %b", outs, O_NONE); else passed++;
    cyc();
    total++;
    if (outs !== O_FAULT) $display("FAIL illegal_fault: got %b exp %b", outs, O_FAULT); else passed++;
    total++;
    if (instr_count !== 16'd0) $display("FAIL illegal_count: got %0d exp 0", instr_count); else passed++;
  endtask

  task automatic test_reset_mid();
    imem_ack = 1'b1; op_class = 3'd1;
    do_reset(1'b0);
    repeat (6) cyc();
    total++;
    if (outs !== O_EXALU) $display("FAIL mid_exec: got %b exp %b", outs, O_EXALU); else passed++;
    #1 n_reset = 1'b0;
    #1;
    total++;
    if (outs !== O_NONE) $display("FAIL mid_reset_outs: got %b exp %b", outs, O_NONE); else passed++;
    total++;
    if (instr_count !== 16'd0) $display("FAIL mid_reset_count: got %0d exp 0", instr_count); else passed++;
    @(posedge clk); #2;
    n_reset = 1'b1;
    #1;
    total++;
    if (outs !== O_NONE) $display("FAIL mid_release_idle: got %b exp %b", outs, O_NONE); else passed++;
    cyc();
    total++;
    if (outs !== O_FACK) $display("FAIL mid_restart_fetch: got %b exp %b", outs, O_FACK); else passed++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wait_states();
    test_timeout();
    test_branch();
    test_single_step();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
